// File: rtl/morphle_pkg.sv
// Shared Morphle yellow-cell definitions: configuration-loader state encoding
// and the cell value codes used by the yellow-cell fabric.
package morphle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WAIT   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5
    } ldr_state_e;

    // Dual-rail cell values: empty, logic 0, logic 1.
    localparam logic [1:0] VEMPTY = 2'b00;
    localparam logic [1:0] V0     = 2'b01;
    localparam logic [1:0] V1     = 2'b10;

endpackage

// File: rtl/yblock_cfg_loader.sv
// Clears a yellow-cell block, then shifts NWORDS configuration words into its cbit chain.
// Define YBLOCK_CFG_READBACK_EN to return the displaced chain contents on rb_valid/rb_data.
module yblock_cfg_loader
    import morphle_pkg::*;
#(
    parameter int BLOCKWIDTH  = 8,
    parameter int BLOCKHEIGHT = 8,
    parameter int CELLBITS    = 3,
    parameter int RSTCYCLES   = 4,
    parameter int NWORDS      = BLOCKHEIGHT * CELLBITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [BLOCKWIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  blk_reset,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbitin,
    input  logic [BLOCKWIDTH-1:0] cbitout,
    output logic                  rb_valid,
    output logic [BLOCKWIDTH-1:0] rb_data,
    output logic                  busy,
    output logic                  done
);

    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int RCNT_W = (RSTCYCLES > 1) ? $clog2(RSTCYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NWORDS);
    localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(RSTCYCLES - 1);

    ldr_state_e            state_d, state_q;
    logic [WCNT_W-1:0]     word_cnt_d, word_cnt_q;
    logic [RCNT_W-1:0]     rst_cnt_d, rst_cnt_q;
    logic [BLOCKWIDTH-1:0] cbitin_d, cbitin_q;
    logic                  blk_reset_d, blk_reset_q;
    logic                  confclk_d, confclk_q;
    logic                  in_ready_d, in_ready_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        cbitin_d    = cbitin_q;
        blk_reset_d = blk_reset_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_CLEAR;
                    word_cnt_d  = '0;
                    rst_cnt_d   = RCNT_INIT;
                    blk_reset_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (rst_cnt_q == '0) begin
                    state_d     = S_WAIT;
                    blk_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    cbitin_d = in_data;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_d == WCNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves the block frozen in reset until a later CLEAR completes.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            blk_reset_d = 1'b1;
            done_d      = 1'b0;
        end

        confclk_d  = (state_d == S_STROBE);
        in_ready_d = (state_d == S_WAIT);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            cbitin_q    <= '0;
            blk_reset_q <= 1'b1;
            confclk_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            cbitin_q    <= cbitin_d;
            blk_reset_q <= blk_reset_d;
            confclk_q   <= confclk_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_reset = blk_reset_q;
    assign confclk   = confclk_q;
    assign cbitin    = cbitin_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef YBLOCK_CFG_READBACK_EN
    logic                  rb_valid_d, rb_valid_q;
    logic [BLOCKWIDTH-1:0] rb_data_d, rb_data_q;

    // Sample the chain tail on the edge that raises confclk, i.e. before that
    // strobe shifts it out; the word is presented with rb_valid during HOLD.
    always_comb begin
        rb_valid_d = (state_d == S_HOLD);
        rb_data_d  = rb_data_q;
        if (state_q == S_SETUP) begin
            rb_data_d = cbitout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            rb_valid_q <= rb_valid_d;
            rb_data_q  <= rb_data_d;
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`else
    logic unused_cbitout;
    assign unused_cbitout = ^cbitout;
    assign rb_valid = 1'b0;
    assign rb_data  = '0;
`endif

endmodule
